// File: rtl/picorv32_mem_responder.sv
// Word RAM answering the picorv32 native memory interface with a fixed number of wait states.
// Out-of-range accesses complete harmlessly but raise the sticky err flag.
module picorv32_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic [15:0] fetch_count,
    output logic [15:0] access_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0]           ram [DEPTH];
    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  oor_q;
    logic                  instr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic [DEPTH_LOG2-1:0] in_idx;
    logic                  in_oor;
    logic                  unused_addr_lsb;

    assign in_idx          = mem_addr[DEPTH_LOG2+1:2];
    assign in_oor          = |mem_addr[31:DEPTH_LOG2+2];
    assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

    // Response data: RAM word for in-range reads, zero for writes and out-of-range.
    function automatic logic [31:0] resp_data(input logic [DEPTH_LOG2-1:0] idx,
                                              input logic oor, input logic [3:0] strb);
        return (oor || strb != 4'd0) ? 32'd0 : ram[idx];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            mem_ready    <= 1'b0;
            mem_rdata    <= 32'd0;
            err          <= 1'b0;
            fetch_count  <= 16'd0;
            access_count <= 16'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        idx_q   <= in_idx;
                        oor_q   <= in_oor;
                        instr_q <= mem_instr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        cnt     <= 4'(WAIT_STATES);
                        if (in_oor) err <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state     <= S_RESP;
                            mem_ready <= 1'b1;
                            mem_rdata <= resp_data(in_idx, in_oor, mem_wstrb);
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= resp_data(idx_q, oor_q, wstrb_q);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state        <= S_IDLE;
                    access_count <= access_count + 16'd1;
                    if (instr_q) fetch_count <= fetch_count + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write lands at the end of RESP; a reset in that same cycle cancels it.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && !oor_q) begin
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Scoreboarded bench: three responder builds (1, 3 and 0 wait states).
module tb_picorv32_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    bit mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // DUT A: WAIT_STATES=1
    logic rst, a_valid, a_instr, a_ready, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0] a_wstrb;
    logic [15:0] a_fetch, a_acc;
    picorv32_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) dut_a (
        .clk(clk), .rst(rst), .mem_valid(a_valid), .mem_instr(a_instr), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_ready(a_ready), .mem_rdata(a_rdata),
        .err(a_err), .fetch_count(a_fetch), .access_count(a_acc));

    // DUT B: WAIT_STATES=3, own reset
    logic rst_b, b_valid, b_ready, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0] b_wstrb;
    logic [15:0] b_fetch, b_acc;
    picorv32_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst(rst_b), .mem_valid(b_valid), .mem_instr(1'b0), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_ready(b_ready), .mem_rdata(b_rdata),
        .err(b_err), .fetch_count(b_fetch), .access_count(b_acc));

    // DUT C: WAIT_STATES=0
    logic c_valid, c_ready, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0] c_wstrb;
    logic [15:0] c_fetch, c_acc;
    picorv32_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_c (
        .clk(clk), .rst(rst), .mem_valid(c_valid), .mem_instr(1'b0), .mem_addr(c_addr),
        .mem_wdata(c_wdata), .mem_wstrb(c_wstrb), .mem_ready(c_ready), .mem_rdata(c_rdata),
        .err(c_err), .fetch_count(c_fetch), .access_count(c_acc));

    typedef struct { logic [31:0] rdata; int at; } exp_t;
    exp_t sb[$];

    // Monitor for DUT A: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_ready) begin
                if (sb.size() == 0) begin
                    chk("a_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("a_rdata", a_rdata, e.rdata);
                    chk("a_ready_cycle", 32'(cyc), 32'(e.at));
                end
            end else begin
                chk("a_rdata_idle", a_rdata, 32'd0);
            end
        end
    end

    // Called just after a posedge; returns just after the edge closing RESP.
    task automatic a_req(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp, input bit hold);
        bit got;
        a_valid = 1'b1; a_instr = instr; a_addr = addr; a_wdata = wdata; a_wstrb = strb;
        sb.push_back('{exp, cyc + 2});
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("a_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) a_valid = 1'b0;
    endtask

    task automatic b_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rd);
        bit got;
        b_valid = 1'b1; b_addr = addr; b_wdata = wdata; b_wstrb = strb;
        got = 1'b0; rd = 32'hx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_ready) begin got = 1'b1; rd = b_rdata; break; end
        end
        if (!got) chk("b_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic c_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rd, output int lat);
        bit got;
        int start;
        start = cyc;
        c_valid = 1'b1; c_addr = addr; c_wdata = wdata; c_wstrb = strb;
        got = 1'b0; rd = 32'hx; lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (c_ready) begin got = 1'b1; rd = c_rdata; lat = cyc - start; break; end
        end
        if (!got) chk("c_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, nready;
        rst = 1'b1; rst_b = 1'b1;
        a_valid = 0; a_instr = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
        b_valid = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0;
        c_valid = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(a_ready), 32'd0);
        chk("reset_rdata", a_rdata, 32'd0);
        chk("reset_err", 32'(a_err), 32'd0);
        chk("reset_fetch", 32'(a_fetch), 32'd0);
        chk("reset_access", 32'(a_acc), 32'd0);
        @(posedge clk); #1;

        // Write then read back
        a_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 0);
        a_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        chk("rw_access", 32'(a_acc), 32'd2);
        chk("rw_fetch", 32'(a_fetch), 32'd0);

        // Byte-enable merge
        a_req(0, 32'h20, 32'h11223344, 4'hF, 32'd0, 0);
        a_req(0, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 0);
        a_req(0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0);

        // Out-of-range read must not alias onto word 0
        a_req(0, 32'h0, 32'hCAFEF00D, 4'hF, 32'd0, 0);
        chk("err_before_oor", 32'(a_err), 32'd0);
        a_req(0, 32'h400, 32'h0, 4'h0, 32'd0, 0);
        chk("err_after_oor", 32'(a_err), 32'd1);
        a_req(0, 32'h400, 32'h99999999, 4'hF, 32'd0, 0);
        a_req(0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0);
        chk("oor_access", 32'(a_acc), 32'd9);

        // Back-to-back fetches with mem_valid held high
        a_req(0, 32'h4, 32'h00000013, 4'hF, 32'd0, 0);
        a_req(0, 32'h8, 32'h00100093, 4'hF, 32'd0, 0);
        a_req(1, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1);
        a_req(1, 32'h4, 32'h0, 4'h0, 32'h00000013, 1);
        a_req(1, 32'h8, 32'h0, 4'h0, 32'h00100093, 0);
        chk("fetch_count", 32'(a_fetch), 32'd3);
        chk("fetch_access", 32'(a_acc), 32'd14);
        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        #1;

        // DUT B: withdrawal during WAIT
        b_req(32'h30, 32'h12345678, 4'hF, rd);
        chk("b_err_clean", 32'(b_err), 32'd0);
        b_valid = 1'b1; b_addr = 32'h30; b_wdata = 32'hFFFFFFFF; b_wstrb = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        nready = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (b_ready) nready++;
        end
        chk("withdraw_no_ready", 32'(nready), 32'd0);
        chk("withdraw_err", 32'(b_err), 32'd1);
        chk("withdraw_access", 32'(b_acc), 32'd1);
        @(posedge clk); #1;
        b_req(32'h30, 32'h0, 4'h0, rd);
        chk("withdraw_ram_kept", rd, 32'h12345678);

        // DUT B: reset coinciding with a write's RESP cycle
        b_valid = 1'b1; b_addr = 32'h30; b_wdata = 32'h0BADF00D; b_wstrb = 4'hF;
        nready = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_ready) begin nready = 1; break; end
        end
        chk("rst_resp_seen", 32'(nready), 32'd1);
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("rst_err", 32'(b_err), 32'd0);
        chk("rst_access", 32'(b_acc), 32'd0);
        chk("rst_fetch", 32'(b_fetch), 32'd0);
        chk("rst_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        b_req(32'h30, 32'h0, 4'h0, rd);
        chk("rst_write_dropped", rd, 32'h12345678);
        chk("rst_access_after", 32'(b_acc), 32'd1);

        // DUT C: zero wait states
        c_req(32'h8, 32'h55AA55AA, 4'hF, rd, lat);
        chk("c_write_rdata", rd, 32'd0);
        c_req(32'h8, 32'h0, 4'h0, rd, lat);
        chk("c_read_rdata", rd, 32'h55AA55AA);
        chk("c_latency", 32'(lat), 32'd1);
        chk("c_access", 32'(c_acc), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
- Single-port word RAM that answers the picorv32 native memory interface.
- Sits directly downstream of the core. Consumes mem_valid, mem_instr, mem_addr, mem_wdata and mem_wstrb.
- Produces mem_ready and mem_rdata with a configurable, fixed number of wait states.
- Gives the fuzzing top-level a self-contained, deterministic memory so the core exercises real fetch/load/store traffic. Out-of-range accesses are flagged instead of aliasing.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words = 1 KiB).
- WAIT_STATES, 1, extra cycles between request acceptance and mem_ready (0..15).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- mem_valid  input  1  core request valid.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 = read.
- mem_ready  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data, valid when mem_ready=1.
- err  output  1  sticky: out-of-range access or request withdrawn mid-wait.
- fetch_count  output  16  completed instruction fetches, wraps at 65535->0.
- access_count  output  16  completed accesses of any kind, wraps.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; mem_ready=0; mem_rdata=0; err=0; fetch_count=0; access_count=0.
  - RAM contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_valid=1, capture addr/wdata/wstrb/instr and load wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - Decrement the counter; go to RESP when it reaches 1->0.
  - If mem_valid drops to 0: return to IDLE, no write, no mem_ready, set err.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - Write committed at the end of this cycle.
  - access_count++; fetch_count++ if instr.
  - Next state IDLE unconditionally.
- Latency: request sampled at edge T -> mem_ready high during cycle T+1+WAIT_STATES. The minimum request-to-request spacing is WAIT_STATES+2 cycles.
- mem_valid still high in the IDLE cycle after RESP is treated as a new request, using freshly sampled inputs.
- Address decode:
  - Word index = mem_addr[DEPTH_LOG2+1:2].
  - In range iff mem_addr[31:DEPTH_LOG2+2]==0.
- In-range read (wstrb=0): mem_rdata = RAM[index] during RESP.
- In-range write: for each i with wstrb[i]=1, RAM[index][8i+7:8i] = wdata[8i+7:8i]. Other bytes are unchanged. mem_rdata = 0 during a write response.
- Out-of-range access:
  - Still completes with mem_ready and counters incremented.
  - Read returns 32'h0000_0000; a write is discarded.
  - err set.
- Read-after-write: a read issued after a write's RESP returns the updated data; there is no bypass hazard because transactions do not overlap.
- mem_ready and mem_rdata are 0 in every cycle except RESP.
- Inputs are ignored outside IDLE, except the mem_valid withdrawal check in WAIT.
- Reset mid-operation (rst in WAIT or RESP):
  - Return to IDLE; outputs cleared per reset values.
  - A write whose RESP cycle coincides with rst is NOT committed.
- err clears only on rst.

Test Plan:
- Reset, then with WAIT_STATES=1 write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; then read 0x10. Required: mem_ready 2 cycles after each accept; read returns 0xDEADBEEF; access_count=2; fetch_count=0.
- Byte-enable merge: write 0x11223344 to 0x20 (wstrb F), then 0xAABBCCDD with wstrb 4'b0101, then read 0x20. Required: read returns 0x11BB33DD.
- Out-of-range with DEPTH_LOG2=8: read 0x400 (index would alias to 0, which holds 0xCAFEF00D). Required: returns 0, err=1, mem_ready still pulses once, RAM[0] unchanged.
- Fetch counting and back-to-back: 3 fetches (mem_instr=1), mem_valid held high continuously across responses, addrs 0x0/0x4/0x8. Required: 3 single-cycle mem_ready pulses spaced WAIT_STATES+2 cycles apart; fetch_count=3.
- Withdrawal and reset: with WAIT_STATES=3, issue a write then drop mem_valid during WAIT. Required: no mem_ready, RAM unchanged, err=1. Then assert rst in the RESP cycle of a second write. Required: write not committed; err=0, counters=0 after reset.
- WAIT_STATES=0 build: read sampled at edge T -> mem_ready high in cycle T+1 with correct data.
